// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs LANES show-ahead FIFO entries into one wide valid/ready word
module fifo_word_packer #(
    parameter int DSIZE   = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DSIZE-1:0]       fifo_rdata,
    input  logic                   fifo_rempty,
    output logic                   fifo_rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] m_data,
    output logic [LANES-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready
);
    localparam int LW = $clog2(LANES) + 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {FILL, OUT} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [DSIZE*LANES-1:0] acc_q, acc_d;
    logic [LANES-1:0]       keep_q, keep_d;

    logic                   pop;
    logic [LW-1:0]          filled;
    logic [LANES-1:0]       part_keep;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        idle_cnt_d = idle_cnt_q;
        acc_d      = acc_q;
        keep_d     = keep_q;
        pop        = (state_q == FILL) && !fifo_rempty;
        filled     = lane_cnt_q + LW'(pop);
        for (int i = 0; i < LANES; i++) begin
            part_keep[i] = (LW'(i) < filled);
        end

        case (state_q)
            FILL: begin
                if (pop) begin
                    acc_d[int'(lane_cnt_q)*DSIZE +: DSIZE] = fifo_rdata;
                    lane_cnt_d = filled;
                    idle_cnt_d = '0;
                end
                // A full word and a flushed partial word leave FILL the same way.
                if (filled == LW'(LANES) || (flush && filled != '0)) begin
                    state_d = OUT;
                    keep_d  = part_keep;
                end else if (TIMEOUT > 0 && lane_cnt_q != '0 && fifo_rempty) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = OUT;
                        keep_d  = part_keep;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d    = FILL;
                    lane_cnt_d = '0;
                    idle_cnt_d = '0;
                    acc_d      = '0;
                    keep_d     = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            lane_cnt_q <= '0;
            idle_cnt_q <= '0;
            acc_q      <= '0;
            keep_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            acc_q      <= acc_d;
            keep_q     <= keep_d;
        end
    end

    // Gated by rst so a pop can never slip out while the FIFO side is being reset.
    assign fifo_rinc = pop && !rst;
    assign m_data    = acc_q;
    assign m_keep    = keep_q;
    assign m_valid   = (state_q == OUT);
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-domain consumer placed directly downstream of the asynchronous FIFO. It pulls DSIZE-bit entries from the FIFO read port (rdata / rinc / rempty) and packs LANES consecutive entries into one wide word. The word is presented on a valid/ready output stream. A partial word is emitted on an explicit flush or after a configurable idle timeout, with a byte-lane keep mask marking which lanes hold data. The block runs entirely on the FIFO read clock.

## Interface
Parameters:
- DSIZE, 8, width of one FIFO entry; must match the FIFO's DSIZE.
- LANES, 4, entries per output word (≥2).
- TIMEOUT, 16, consecutive empty cycles before a partial word is forced out; 0 disables the timeout.

Ports:
- clk  in  1  read-domain clock, the same clock as the FIFO rclk.
- rst  in  1  asynchronous, active-high reset.
- fifo_rdata  in  DSIZE  FIFO head entry; valid whenever fifo_rempty=0 (show-ahead).
- fifo_rempty  in  1  FIFO empty flag.
- fifo_rinc  out  1  pop strobe; combinational.
- flush  in  1  request emission of the current partial word.
- m_data  out  DSIZE*LANES  packed word; lane i = bits [DSIZE*i +: DSIZE]; lane 0 holds the first entry.
- m_keep  out  LANES  lane-valid mask; contiguous from bit 0.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.

## Operation
- Two states: FILL and OUT. Internal registers: lane_cnt (log2(LANES)+1 bits), idle_cnt (sized for TIMEOUT), data accumulator, keep register.
- **FILL**
  - fifo_rinc = ~fifo_rempty. m_valid = 0.
  - On pop: fifo_rdata is written into lane lane_cnt, lane_cnt increments, idle_cnt clears.
  - Pop with lane_cnt = LANES-1: go to OUT, m_keep = all ones.
  - flush = 1 with (lane_cnt > 0 or a pop this cycle): the pop, if any, is included; go to OUT with m_keep = (1 << filled lanes) - 1.
  - flush with lane_cnt = 0 and no pop: ignored.
  - Timeout (TIMEOUT > 0): idle_cnt increments each cycle with lane_cnt > 0 and fifo_rempty = 1. When idle_cnt = TIMEOUT-1 on such a cycle, go to OUT with a partial keep. idle_cnt is held at 0 while lane_cnt = 0.
- **OUT**
  - m_valid = 1; fifo_rinc = 0; m_data and m_keep are held stable.
  - flush is ignored.
  - m_ready = 1: go to FILL, lane_cnt = 0, idle_cnt = 0, accumulator and keep clear to 0.
- Unfilled lanes of m_data are always 0.
- fifo_rinc is never asserted while fifo_rempty = 1, in OUT, or during rst. The block therefore never underflows the FIFO.

## Timing
- **Reset** (asynchronous assert, synchronous release): state = FILL, m_valid = 0, m_data = 0, m_keep = 0, lane_cnt = 0, idle_cnt = 0, fifo_rinc = 0.
- **Latency:** word completes on the pop at edge N; m_valid = 1 after edge N, i.e. in cycle N+1.
- **Throughput:** at most LANES entries per LANES+1 cycles with m_ready tied high. There is no pop in the OUT cycle.
- **Timeout:** last pop at edge N with rempty high afterwards gives m_valid = 1 after edge N+TIMEOUT.
- **Flush:** flush sampled at edge N gives m_valid = 1 after edge N.
- **Reset mid-word or mid-OUT:** the partial or pending word is discarded; no output is produced for it.
- **Handshake:** m_valid stays high until m_ready. The word transfers on the edge where m_valid & m_ready.

## Test plan
- **Full word:** reset, then push 0x11, 0x22, 0x33, 0x44 into the FIFO with m_ready = 1. Expect m_data = 0x44332211, m_keep = 4'b1111, one m_valid cycle, and exactly 4 fifo_rinc pulses.
- **Backpressure:** 8 entries 0x01..0x08 with m_ready = 0 for 10 cycles. Expect m_data = 0x04030201 held stable, fifo_rinc = 0 throughout OUT, and no pop of 0x05 until the handshake. The second word is 0x08070605.
- **Timeout:** push 0xAA, 0xBB, then nothing; TIMEOUT = 16. Expect m_valid rising exactly 16 cycles after the 0xBB pop, with m_data = 0x0000BBAA and m_keep = 4'b0011.
- **Flush:** push 0x5A, then pulse flush. Expect m_data = 0x0000005A and m_keep = 4'b0001. A flush with an empty accumulator and empty FIFO produces no m_valid.
- **Reset mid-operation:** pop 3 entries, assert rst for 1 cycle. Expect m_valid = 0, m_data = 0, m_keep = 0 immediately. The next 4 pops form a fresh full word.
- **Empty gating:** randomly toggle fifo_rempty and m_ready over 1000 entries. Expect the scoreboard to show the byte stream preserved in order, and fifo_rinc never high while fifo_rempty = 1.
